// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to build the parity state; without it parity_mode_i is ignored.
module uart_tx_frame #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int CLK_DIV   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic [1:0]           parity_mode_i,
  output logic                 tx_ready_o,
  output logic                 tx_bit_o,
  output logic                 busy_o
);

  localparam int BW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_tx_frame: CLK_DIV must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 tx_bit_q, tx_bit_d;
  logic                 bit_end;

`ifdef UART_TX_PARITY_EN
  // Parity bit is resolved at acceptance: XOR of the word, inverted for odd mode.
  logic par_en_q, par_en_d;
  logic par_q, par_d;
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode_i;
`endif

  assign bit_end    = (baud_q == BAUD_LAST);
  assign tx_ready_o = (state_q == S_IDLE);
  assign busy_o     = ~tx_ready_o;
  assign tx_bit_o   = tx_bit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      sh_q     <= '0;
      tx_bit_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      sh_q     <= sh_d;
      tx_bit_q <= tx_bit_d;
`ifdef UART_TX_PARITY_EN
      par_en_q <= par_en_d;
      par_q    <= par_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    sh_d     = sh_q;
    tx_bit_d = tx_bit_q;
`ifdef UART_TX_PARITY_EN
    par_en_d = par_en_q;
    par_d    = par_q;
`endif
    // Counter saturates at BAUD_LAST; every bit-state entry below reloads it to 0.
    if (state_q != S_IDLE && !bit_end) baud_d = baud_q + BW'(1);

    case (state_q)
      S_IDLE: begin
        if (tx_valid_i) begin
          state_d  = S_START;
          tx_bit_d = 1'b0;
          baud_d   = '0;
          idx_d    = '0;
          stop_d   = 1'b0;
          sh_d     = tx_data_i;
`ifdef UART_TX_PARITY_EN
          par_en_d = ^parity_mode_i;
          par_d    = (^tx_data_i) ^ parity_mode_i[1];
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d  = S_DATA;
          tx_bit_d = sh_q[0];
          sh_d     = sh_q >> 1;
          baud_d   = '0;
          idx_d    = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d  = S_STOP;
            tx_bit_d = 1'b1;
            stop_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d  = S_PARITY;
              tx_bit_d = par_q;
            end
`endif
          end else begin
            idx_d    = idx_q + IW'(1);
            tx_bit_d = sh_q[0];
            sh_d     = sh_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d  = S_STOP;
          tx_bit_d = 1'b1;
          baud_d   = '0;
          stop_d   = 1'b0;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (stop_q == STOP_LAST) state_d = S_IDLE;
          else                     stop_d  = 1'b1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        tx_bit_d = 1'b1;
      end
    endcase
  end

endmodule
